// File: rtl/pwm_compare_pkg.sv
// Shared types and helpers for the PWM compare stage: handshake states, counter limits, duty clamp.
// Used by pwm_compare_stage and its testbench.
package pwm_compare_pkg;

    localparam int PKG_CNT_W = 4;
    localparam int MAX_CNT   = (1 << PKG_CNT_W) - 1;

    typedef logic [0:0] hs_state_t;
    localparam hs_state_t ST_IDLE    = 1'b0;
    localparam hs_state_t ST_PENDING = 1'b1;

    // A full-period duty is 2^cnt_w; anything larger means "always high".
    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned cnt_w);
        int unsigned full;
        full = 32'd1 << cnt_w;
        return (duty > full) ? full : duty;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time gating: both complementary outputs held low for DEAD_CYC clocks after each raw edge.
// Outputs are combinational from registered state; raw is expected to come from a register.
module pwm_deadtime #(
    parameter int DEAD_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    output logic pwm_out,
    output logic pwm_out_n
);

    localparam int DW = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);

    logic [DW-1:0] dead_q;
    logic          raw_prev;
    logic          edge_det;
    logic          dead_zero;

    // The edge cycle itself counts as the first dead cycle, so reload with DEAD_CYC-1.
    assign edge_det  = (raw != raw_prev);
    assign dead_zero = !edge_det && (dead_q == '0);
    assign pwm_out   = raw && dead_zero;
    assign pwm_out_n = !raw && dead_zero && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dead_q   <= '0;
            raw_prev <= 1'b0;
        end else begin
            raw_prev <= raw;
            if (edge_det) begin
                dead_q <= DW'(DEAD_CYC - 1);
            end else if (dead_q != '0) begin
                dead_q <= dead_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_compare_stage.sv
// Compares the upstream counter against a double-buffered duty and emits a registered PWM plus period events.
// PWM_COMPL_EN adds pwm_out_n with dead-time gating via pwm_deadtime.
module pwm_compare_stage
    import pwm_compare_pkg::*;
#(
    parameter int CNT_W    = PKG_CNT_W,
    parameter int PER_W    = 8,
    parameter int DEAD_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] counter,
    input  logic             enable,
    input  logic [CNT_W:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
`ifdef PWM_COMPL_EN
    output logic             pwm_out_n,
`endif
    output logic             wrap_pulse,
    output logic             short_period,
    output logic [PER_W-1:0] period_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);

    if (DEAD_CYC < 1 || DEAD_CYC > (1 << CNT_W) - 1) begin : g_bad_dead
        $error("DEAD_CYC out of range");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   active_duty;
    logic [CNT_W:0]   pending_duty;
    logic [CNT_W:0]   eff_duty;
    hs_state_t        state;
    logic             boundary;
    logic             at_max;
    logic             cmp;

    // A boundary is the first cycle the counter reads zero; the pending duty is used right then.
    assign boundary   = (counter == '0) && (cnt_q != '0);
    assign at_max     = (cnt_q == CNT_MAX);
    assign eff_duty   = (boundary && state == ST_PENDING) ? pending_duty : active_duty;
    assign cmp        = enable && ({1'b0, counter} < eff_duty);
    assign duty_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            wrap_pulse   <= 1'b0;
            short_period <= 1'b0;
            period_cnt   <= '0;
        end else begin
            cnt_q        <= counter;
            wrap_pulse   <= boundary && at_max;
            short_period <= boundary && !at_max;
            if (boundary && at_max) begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    // A transfer accepted on a boundary cycle waits for the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            active_duty  <= '0;
            pending_duty <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (duty_valid) begin
                        pending_duty <= (CNT_W+1)'(clamp_duty(32'(duty_in), CNT_W));
                        state        <= ST_PENDING;
                    end
                end
                default: begin
                    if (boundary) begin
                        active_duty <= pending_duty;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PWM_COMPL_EN
    logic raw_q;
    logic en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            raw_q <= cmp;
            en_q  <= enable;
        end
    end

    pwm_deadtime #(
        .DEAD_CYC (DEAD_CYC)
    ) u_deadtime (
        .clk       (clk),
        .reset     (reset),
        .raw       (raw_q),
        .enable    (en_q),
        .pwm_out   (pwm_out),
        .pwm_out_n (pwm_out_n)
    );
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= cmp;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Scoreboard bench for pwm_compare_stage: a reference model pushes expected outputs per driven cycle,
// popped and compared after the clock edge; directed checks count high cycles per period.
module tb_pwm_compare_stage;
    import pwm_compare_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] counter;
    logic       enable;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       short_period;
    logic [7:0] period_cnt;

    pwm_compare_stage #(
        .CNT_W    (4),
        .PER_W    (8),
        .DEAD_CYC (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .counter      (counter),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .short_period (short_period),
        .period_cnt   (period_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pwm;
        logic       wrap;
        logic       shrt;
        logic       rdy;
        logic [7:0] per;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_prev;
    int         m_active;
    int         m_pending;
    bit         m_pend;
    logic [7:0] m_per;
    logic [3:0] ctr;
    bit         en;
    int         wraps_seen;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input int d);
        exp_t e;
        bit   bnd;
        int   eff;
        @(negedge clk);
        counter    = ctr;
        enable     = en;
        duty_valid = v;
        duty_in    = 5'(d);
        bnd   = (ctr == 4'd0) && (m_prev != 0);
        eff   = (bnd && m_pend) ? m_pending : m_active;
        e.pwm  = en && (int'(ctr) < eff);
        e.wrap = bnd && (m_prev == MAX_CNT);
        e.shrt = bnd && (m_prev != MAX_CNT);
        if (e.wrap) m_per = m_per + 8'd1;
        if (m_pend) begin
            if (bnd) begin
                m_active = m_pending;
                m_pend   = 1'b0;
            end
        end else if (v) begin
            m_pending = (d > 16) ? 16 : d;
            m_pend    = 1'b1;
        end
        e.rdy  = !m_pend;
        e.per  = m_per;
        m_prev = int'(ctr);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pwm_out", pwm_out, e.pwm);
            chk("wrap_pulse", wrap_pulse, e.wrap);
            chk("short_period", short_period, e.shrt);
            chk("duty_ready", duty_ready, e.rdy);
            chk("period_cnt", period_cnt, e.per);
        end
        if (wrap_pulse) wraps_seen++;
        ctr = ctr + 4'd1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        duty_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            counter = ctr;
            @(posedge clk);
            #1;
            chk("rst_pwm", pwm_out, 0);
            chk("rst_wrap", wrap_pulse, 0);
            chk("rst_short", short_period, 0);
            chk("rst_per", period_cnt, 0);
            chk("rst_ready", duty_ready, 1);
            ctr = ctr + 4'd1;
        end
        reset     = 1'b0;
        m_prev    = 0;
        m_active  = 0;
        m_pending = 0;
        m_pend    = 1'b0;
        m_per     = 8'd0;
        sb.delete();
    endtask

    task automatic goto(input int at);
        while (ctr != 4'(at)) step(1'b0, 0);
    endtask

    task automatic send(input int at, input int d);
        goto(at);
        step(1'b1, d);
    endtask

    task automatic run_period(input bit v, input int d, output int highs,
                              output bit fs, output bit fw, output int fper);
        highs = 0;
        fs = 1'b0;
        fw = 1'b0;
        fper = 0;
        for (int i = 0; i < 16; i++) begin
            step((i == 0) ? v : 1'b0, d);
            highs += int'(pwm_out);
            if (i == 0) begin
                fs   = short_period;
                fw   = wrap_pulse;
                fper = int'(period_cnt);
            end
        end
    endtask

    initial begin
        int h;
        bit fs;
        bit fw;
        int fp;
        int per0;

        ctr = 4'd0; en = 1'b1; reset = 1'b1; enable = 1'b1;
        counter = 4'd0; duty_in = 5'd0; duty_valid = 1'b0;
        m_prev = 0; m_active = 0; m_pending = 0; m_pend = 1'b0; m_per = 8'd0;
        wraps_seen = 0;

        do_reset();
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("post_reset_highs", h, 0);

        send(7, 5);
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("duty5_highs_p1", h, 5);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("duty5_highs_p2", h, 5);
        chk("duty5_ready_back", duty_ready, 1);

        send(3, 0);
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("duty0_highs", h, 0);

        send(3, 16);
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("duty16_highs", h, 16);

        send(3, 31);
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("duty31_clamp_highs", h, 16);

        // Accept on the boundary cycle: old duty this period, new duty next.
        run_period(1'b1, 3, h, fs, fw, fp);
        chk("simul_same_period", h, 16);
        chk("simul_wrap_seen", fw, 1);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("simul_next_period", h, 3);

        en = 1'b0;
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("disabled_highs", h, 0);
        en = 1'b1;
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("reenabled_highs", h, 3);

        // Upstream counter restarts at 9 with a duty pending.
        send(4, 7);
        goto(9);
        per0 = int'(period_cnt);
        ctr = 4'd0;
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("short_flag", fs, 1);
        chk("short_no_wrap", fw, 0);
        chk("short_per_same", fp, per0);
        chk("short_loaded_highs", h, 7);

        per0 = int'(period_cnt);
        wraps_seen = 0;
        for (int p = 0; p < 256; p++) begin
            run_period(1'b0, 0, h, fs, fw, fp);
        end
        chk("wrap_count_256", wraps_seen, 256);
        chk("period_cnt_rollover", period_cnt, per0);
        chk("long_run_highs", h, 7);

        // Reset while pending must drop the pending duty.
        send(3, 9);
        chk("pend_ready_low", duty_ready, 0);
        do_reset();
        goto(0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("pend_discard_highs", h, 0);
        run_period(1'b0, 0, h, fs, fw, fp);
        chk("pend_discard_highs2", h, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
